rr_burst_arbiter: RTL and testbench

Four-way round-robin arbiter with burst hold for a single shared resource. A granted requester keeps ownership while it holds its request, up to `MAX_BURST` consecutive cycles. After that, ownership rotates if anyone else is waiting. It sits between the requesting masters and the shared datapath. It extends the plain single-cycle round-robin grant with ownership tracking, a burst counter and a rotating priority pointer.

---
 rtl/rr_burst_arbiter.sv | 116 +++++++++++
 tb/tb_rr_burst_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter for up to N requesters with burst hold: an owner keeps the
// grant while it requests, and rotates away after MAX_BURST cycles if others wait.
module rr_burst_arbiter #(
    parameter int N         = 4,
    parameter int MAX_BURST = 4,
    parameter int CW        = $clog2(MAX_BURST)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         REQ,
    output logic [N-1:0]         GNT,
    output logic [$clog2(N)-1:0] GNT_ID,
    output logic                 BUSY,
    output logic [CW-1:0]        BURST_CNT
);

    localparam int IW = $clog2(N);

    typedef enum logic {IDLE, OWN} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   ptr, ptr_nx;
    logic [IW-1:0]   own, own_nx, own_inc;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [N-1:0]    gnt;
    logic            busy;
    logic [N-1:0]    others;
    logic            release_now;
    logic            expire;

    // First index at or after start (wrapping) whose mask bit is set.
    function automatic logic [IW-1:0] pick(input logic [IW-1:0] start,
                                           input logic [N-1:0]  mask);
        logic [IW-1:0] res;
        int            idx;
        res = start;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % N;
            if (mask[idx]) res = IW'(idx);
        end
        return res;
    endfunction

    assign own_inc     = (own == IW'(N - 1)) ? '0 : own + IW'(1);
    assign others      = REQ & ~(N'(1) << own);
    assign release_now = !REQ[own];
    assign expire      = (cnt == CW'(MAX_BURST - 1));

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            own   <= '0;
            cnt   <= '0;
            gnt   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            own   <= own_nx;
            cnt   <= cnt_nx;
            busy  <= (state_nx == OWN);
            gnt   <= (state_nx == OWN) ? (N'(1) << own_nx) : '0;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|REQ) state_nx = OWN;
            OWN:     if (release_now && !(|others)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Release takes precedence over expiry when both happen on the same edge.
    always_comb begin
        own_nx = own;
        cnt_nx = cnt;
        ptr_nx = ptr;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (|REQ) own_nx = pick(ptr, REQ);
            end
            OWN: begin
                if (release_now) begin
                    ptr_nx = own_inc;
                    cnt_nx = '0;
                    if (|others) own_nx = pick(own_inc, others);
                end else if (expire) begin
                    cnt_nx = '0;
                    if (|others) begin
                        own_nx = pick(own_inc, others);
                        ptr_nx = own_inc;
                    end
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: begin
                own_nx = own;
                cnt_nx = '0;
                ptr_nx = ptr;
            end
        endcase
    end

    assign GNT       = gnt;
    assign GNT_ID    = own;
    assign BUSY      = busy;
    assign BURST_CNT = cnt;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed bench for rr_burst_arbiter: a cycle model checked every edge plus
// hand-computed expectations for the reset, contention, handover and idle cases.
module tb_rr_burst_arbiter;

    localparam int N    = 4;
    localparam int MAXB = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic [1:0] burst_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    rr_burst_arbiter #(.N(N), .MAX_BURST(MAXB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .REQ      (req),
        .GNT      (gnt),
        .GNT_ID   (gnt_id),
        .BUSY     (busy),
        .BURST_CNT(burst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner id (valid when m_busy), cycles held so far minus one, pointer.
    bit m_valid = 1'b0;
    bit m_busy;
    int m_id, m_cnt, m_ptr;

    function automatic int mpick(input int start, input logic [3:0] mask);
        for (int k = 0; k < N; k++)
            if (mask[(start + k) % N]) return (start + k) % N;
        return -1;
    endfunction

    task automatic model_step();
        logic [3:0] others;
        int         held;
        if (!rst_n) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_id    = 0;
            m_cnt   = 0;
            m_ptr   = 0;
        end else if (m_valid) begin
            if (!m_busy) begin
                if (req != 4'b0) begin
                    m_id   = mpick(m_ptr, req);
                    m_busy = 1'b1;
                    m_cnt  = 0;
                end
            end else begin
                others       = req;
                others[m_id] = 1'b0;
                held         = m_cnt + 1;
                if (!req[m_id] || (held == MAXB && others != 4'b0)) begin
                    m_ptr = (m_id + 1) % N;
                    m_cnt = 0;
                    if (others != 4'b0) m_id = mpick(m_ptr, others);
                    else m_busy = 1'b0;
                end else begin
                    m_cnt = held % MAXB;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        logic [3:0] e_gnt;
        model_step();
        #1;
        if (m_valid) begin
            e_gnt = m_busy ? 4'(1 << m_id) : 4'b0;
            check("model_gnt",  32'(gnt),       32'(e_gnt));
            check("model_id",   32'(gnt_id),    32'(m_id));
            check("model_busy", 32'(busy),      32'(m_busy));
            check("model_cnt",  32'(burst_cnt), 32'(m_cnt));
        end
    end

    task automatic drive(input logic [3:0] r, input logic rn);
        @(negedge clk);
        req   = r;
        rst_n = rn;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b1111;

        // Reset held two edges with everyone requesting.
        tick();
        tick();
        check("rst_gnt",  32'(gnt),       32'h0);
        check("rst_id",   32'(gnt_id),    32'h0);
        check("rst_busy", 32'(busy),      32'h0);
        check("rst_cnt",  32'(burst_cnt), 32'h0);

        // Full contention from ptr=0: 4-cycle slots rotating 0,1,2,3,0.
        drive(4'b1111, 1'b1);
        tick();
        check("first_gnt", 32'(gnt), 32'h1);
        for (int c = 0; c <= 16; c++) begin
            if (c != 0) tick();
            check("fc_gnt", 32'(gnt),       32'(1 << ((c / 4) % 4)));
            check("fc_cnt", 32'(burst_cnt), 32'(c % 4));
        end
        for (int c = 17; c <= 21; c++) tick();
        check("pre_ho_gnt", 32'(gnt),       32'h2);
        check("pre_ho_cnt", 32'(burst_cnt), 32'h1);

        // Early release by owner 1: hands straight to 3 with no idle gap.
        drive(4'b1001, 1'b1);
        tick();
        check("ho_gnt",  32'(gnt),       32'h8);
        check("ho_id",   32'(gnt_id),    32'h3);
        check("ho_cnt",  32'(burst_cnt), 32'h0);
        check("ho_busy", 32'(busy),      32'h1);

        // Owner 3 releases to 2, then 2 drops to idle (ptr becomes 3).
        drive(4'b0100, 1'b1);
        tick();
        check("to2_gnt", 32'(gnt), 32'h4);
        drive(4'b0000, 1'b1);
        tick();
        check("idle_gnt",  32'(gnt),    32'h0);
        check("idle_busy", 32'(busy),   32'h0);
        check("idle_id",   32'(gnt_id), 32'h2);
        drive(4'b0111, 1'b1);
        tick();
        check("wrap_gnt", 32'(gnt), 32'h1);

        // Lone holder from a fresh reset: keeps grant, counter wraps.
        drive(4'b0000, 1'b0);
        drive(4'b1000, 1'b1);
        tick();
        check("lone_id", 32'(gnt_id), 32'h3);
        for (int c = 0; c < 10; c++) begin
            if (c != 0) tick();
            check("lone_gnt", 32'(gnt),       32'h8);
            check("lone_cnt", 32'(burst_cnt), 32'(c % 4));
        end

        // Mid-burst reset while owner 1 holds.
        drive(4'b0110, 1'b1);
        tick();
        check("mb_gnt", 32'(gnt), 32'h2);
        tick();
        drive(4'b0110, 1'b0);
        tick();
        check("mb_rst_gnt", 32'(gnt),    32'h0);
        check("mb_rst_id",  32'(gnt_id), 32'h0);
        drive(4'b0110, 1'b1);
        tick();
        check("mb_after_gnt", 32'(gnt), 32'h2);

        // Reset must clear a nonzero pointer: owner 1 releases to 3 (ptr=2).
        drive(4'b1001, 1'b1);
        tick();
        check("p2_gnt", 32'(gnt), 32'h8);
        drive(4'b1001, 1'b0);
        drive(4'b1001, 1'b1);
        tick();
        check("ptr_rst_gnt", 32'(gnt), 32'h1);

        // Release coinciding with expiry resolves as release: owner 0 at cnt 3 drops.
        for (int c = 1; c < 4; c++) tick();
        check("exp_cnt", 32'(burst_cnt), 32'h3);
        drive(4'b0110, 1'b1);
        tick();
        check("relexp_gnt", 32'(gnt), 32'h2);
        drive(4'b0000, 1'b1);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
